// File: rtl/jk_excitation_driver.sv
// Drives J/K excitation for one cycle to move an external JK register bank to a
// requested state, then confirms the move from the bank's Q feedback and retries.
module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_state,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       retries
);

  // Handshake: a request transfers on a rising clk where req_valid && req_ready
  // are both high; req_ready is high only in IDLE and req_state is latched then.

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  // Internal attempt counter wide enough for MAX_RETRY; the retries port saturates at 3.
  localparam int CW = $clog2(MAX_RETRY + 2);

  state_t           state, state_n;
  logic [WIDTH-1:0] target, target_n;
  logic [WIDTH-1:0] j_n, k_n;
  logic [WIDTH-1:0] ex_t, ex_j, ex_k;
  logic             done_n, err_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [1:0]       retries_n;

  // Excitation always derives from the live bank value and the goal being driven.
  assign ex_t = (state == IDLE) ? req_state : target;

  generate
    if (USE_TOGGLE != 0) begin : g_toggle
      assign ex_j = q_fb ^ ex_t;
      assign ex_k = q_fb ^ ex_t;
    end else begin : g_setreset
      assign ex_j = ~q_fb & ex_t;
      assign ex_k = q_fb & ~ex_t;
    end
  endgenerate

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n   = state;
    target_n  = target;
    j_n       = '0;
    k_n       = '0;
    done_n    = 1'b0;
    err_n     = err;
    cnt_n     = cnt;
    retries_n = retries;
    case (state)
      IDLE: begin
        if (req_valid) begin
          target_n  = req_state;
          err_n     = 1'b0;
          cnt_n     = '0;
          retries_n = 2'd0;
          j_n       = ex_j;
          k_n       = ex_k;
          state_n   = DRIVE;
        end
      end
      DRIVE: state_n = CHECK;
      CHECK: begin
        if (q_fb == target) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt < CW'(MAX_RETRY)) begin
          cnt_n     = cnt + CW'(1);
          retries_n = (retries == 2'd3) ? 2'd3 : retries + 2'd1;
          j_n       = ex_j;
          k_n       = ex_k;
          state_n   = DRIVE;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      target  <= '0;
      J       <= '0;
      K       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      retries <= 2'd0;
    end else begin
      state   <= state_n;
      target  <= target_n;
      J       <= j_n;
      K       <= k_n;
      done    <= done_n;
      err     <= err_n;
      cnt     <= cnt_n;
      retries <= retries_n;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (set/reset and toggle encoding),
// each driving a behavioural JK bank model with optional stuck/drop faults.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_state = '0;

  logic [3:0] q0, j0, k0, q1, j1, k1;
  logic       rdy0, busy0, done0, err0, rdy1, busy1, done1, err1;
  logic [1:0] ret0, ret1;

  // bank control: mode 0 normal, 1 stuck, 2 ignore the first non-idle drive
  logic       bank_load = 1'b0;
  logic [3:0] bank_val  = '0;
  int         bank_mode = 0;
  logic       drop_armed = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(4), .MAX_RETRY(2), .USE_TOGGLE(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
    .req_state(req_state), .q_fb(q0), .J(j0), .K(k0), .busy(busy0),
    .done(done0), .err(err0), .retries(ret0));

  jk_excitation_driver #(.WIDTH(4), .MAX_RETRY(2), .USE_TOGGLE(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_state(req_state), .q_fb(q1), .J(j1), .K(k1), .busy(busy1),
    .done(done1), .err(err1), .retries(ret1));

  function automatic logic [3:0] jk_next(input logic [3:0] q, j, k);
    for (int b = 0; b < 4; b++)
      jk_next[b] = (j[b] & k[b]) ? ~q[b] : j[b] ? 1'b1 : k[b] ? 1'b0 : q[b];
  endfunction

  always @(posedge clk) begin
    if (bank_load) begin
      q0 <= bank_val;
      q1 <= bank_val;
      drop_armed <= 1'b1;
    end else begin
      q1 <= jk_next(q1, j1, k1);
      if (bank_mode == 1) q0 <= q0;
      else if (bank_mode == 2 && drop_armed && (j0 != 0 || k0 != 0)) drop_armed <= 1'b0;
      else q0 <= jk_next(q0, j0, k0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_bank(input logic [3:0] v, input int mode);
    @(negedge clk);
    bank_load = 1'b1;
    bank_val  = v;
    bank_mode = mode;
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  // Present a request at a negedge; returns after the accepting posedge.
  task automatic issue(input logic [3:0] r);
    @(negedge clk);
    chk("ready_before_req", {rdy0, rdy1}, 2'b11);
    req_valid = 1'b1;
    req_state = r;
    @(posedge clk);
  endtask

  // Observe instance 0 from DRIVE until it returns to IDLE; bounded by max cycles.
  task automatic run_to_idle(input int max, output int drives, output logic saw_done,
                             output logic [3:0] lj, output logic [3:0] lk);
    logic finished;
    drives = 0; saw_done = 1'b0; lj = '0; lk = '0; finished = 1'b0;
    for (int i = 0; i < max && !finished; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (busy0 && (j0 != 0 || k0 != 0)) begin
        drives++; lj = j0; lk = k0;
      end
      if (done0) saw_done = 1'b1;
      if (rdy0) finished = 1'b1;
    end
    chk("idle_within_budget", {31'd0, finished}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] q;
    logic [3:0] req;
    logic [3:0] j0, k0, j1, k1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         drives;
    logic       sd;
    logic [3:0] lj, lk;

    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010};
    vecs[1] = '{4'b1100, 4'b0110, 4'b0010, 4'b1000, 4'b1010, 4'b1010};
    vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
    vecs[4] = '{4'b0011, 4'b1001, 4'b1000, 4'b0010, 4'b1010, 4'b1010};

    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_jk", {j0, k0, j1, k1}, 16'h0);
    chk("rst_flags", {rdy0, busy0, done0, err0, ret0}, 6'b100000);
    rst = 1'b0;

    // table: one-cycle drive, check cycle, done pulse
    for (int v = 0; v < 5; v++) begin
      set_bank(vecs[v].q, 0);
      issue(vecs[v].req);
      @(negedge clk);
      req_valid = 1'b0;
      req_state = ~vecs[v].req;
      chk($sformatf("v%0d_drive_j0k0", v), {j0, k0}, {vecs[v].j0, vecs[v].k0});
      chk($sformatf("v%0d_drive_j1k1", v), {j1, k1}, {vecs[v].j1, vecs[v].k1});
      chk($sformatf("v%0d_drive_flags", v), {busy0, rdy0, busy1, rdy1}, 4'b1010);
      @(negedge clk);
      chk($sformatf("v%0d_check_jk", v), {j0, k0, j1, k1}, 16'h0);
      chk($sformatf("v%0d_check_nodone", v), {done0, done1, busy0}, 3'b001);
      @(negedge clk);
      chk($sformatf("v%0d_done", v), {done0, rdy0, err0, ret0, done1, rdy1, err1},
          8'b11000110);
      chk($sformatf("v%0d_bank", v), {q0, q1}, {vecs[v].req, vecs[v].req});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), {done0, done1}, 2'b00);
    end

    // stuck bank: three drives, retries exhausted
    set_bank(4'b0000, 1);
    issue(4'b0001);
    run_to_idle(20, drives, sd, lj, lk);
    chk("stuck_drives", drives, 3);
    chk("stuck_done_err_ret", {sd, err0, ret0}, 4'b0110);
    @(negedge clk);
    chk("stuck_err_sticky", {err0, done0}, 2'b10);

    // next accepted request clears err
    set_bank(4'b0000, 0);
    chk("err_held_idle", {31'd0, err0}, 32'd1);
    issue(4'b0100);
    @(negedge clk);
    req_valid = 1'b0;
    chk("err_cleared_on_accept", {err0, ret0, j0}, 7'b0000100);
    run_to_idle(10, drives, sd, lj, lk);
    chk("clear_done", {sd, err0}, 2'b10);

    // first drive dropped: one retry
    set_bank(4'b0000, 2);
    issue(4'b1111);
    run_to_idle(20, drives, sd, lj, lk);
    chk("drop_drives", drives, 2);
    chk("drop_retry_jk", {lj, lk}, 8'b11110000);
    chk("drop_done_ret", {sd, err0, ret0, q0}, 8'b10011111);

    // back-to-back with req_valid held high
    set_bank(4'b0000, 0);
    issue(4'b0011);
    @(negedge clk);
    req_state = 4'b0101;
    chk("b2b_first_drive", {j0, k0}, 8'b00110000);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done_ready", {done0, rdy0, req_valid}, 3'b111);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_drive", {busy0, j0, k0}, 9'b101000010);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_second_done", {done0, q0}, 5'b10101);

    // reset during a retry CHECK abandons the request
    set_bank(4'b0000, 1);
    issue(4'b0001);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_check", {busy0, j0, k0, ret0}, 11'b10000000001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", {rdy0, busy0, done0, err0, ret0, j0, k0}, 14'b10000000000000);
    @(negedge clk);
    chk("rst_mid_quiet", {done0, err0, busy0}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
